// File: rtl/bits_ifetch_if.sv
// rtl/bits_ifetch_if.sv - imem read bus and decode-core window bundle for bits_ifetch
interface bits_ifetch_if;
  logic         imem_ceb;
  logic [15:0]  imem_addr;
  logic [63:0]  imem_rdata;
  logic         consume_en;
  logic [4:0]   consume_bytes;
  logic [127:0] instruction_word;
  logic [15:0]  instruction_byte_valid;

  modport master (
    output imem_ceb, imem_addr, instruction_word, instruction_byte_valid,
    input  imem_rdata, consume_en, consume_bytes
  );

  modport slave (
    input  imem_ceb, imem_addr, instruction_word, instruction_byte_valid,
    output imem_rdata, consume_en, consume_bytes
  );
endinterface

// File: rtl/bits_ifetch.sv
// rtl/bits_ifetch.sv - instruction fetch/alignment stage feeding a 16-byte window to the decode core
module bits_ifetch #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        resetB,
  input  logic        start,
  input  logic [15:0] expectedBytes,
  bits_ifetch_if.master bus,
  output logic        done_reading_memory,
  output logic        busy,
  output logic        err_underflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [15:0]  exp_q, exp_d;
  logic [15:0]  issued_q, issued_d;
  logic [15:0]  returned_q, returned_d;
  logic [4:0]   valid_q, valid_d;
  logic         inflight_q, inflight_d;
  logic [127:0] word_q, word_d;
  logic         err_q, err_d;

  logic         issue;
  logic [15:0]  rem_iss, rem_ret, iss_n;
  logic [3:0]   ret_n;
  logic [4:0]   take, v;
  logic [63:0]  ret_mask;
  logic [127:0] win;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    valid_d    = valid_q;
    inflight_d = 1'b0;
    word_d     = word_q;
    err_d      = err_q;
    win        = word_q;
    v          = valid_q;

    rem_iss  = exp_q - issued_q;
    rem_ret  = exp_q - returned_q;
    iss_n    = (rem_iss > 16'd8) ? 16'd8 : rem_iss;
    ret_n    = (rem_ret >= 16'd8) ? 4'd8 : rem_ret[3:0];
    take     = (bus.consume_bytes > valid_q) ? valid_q : bus.consume_bytes;
    ret_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {ret_n, 3'b000});

    // Registered occupancy only: a consume in this cycle does not open room for a read.
    issue = !resetB && (state_q == S_RUN) && !start && (issued_q < exp_q) &&
            ({1'b0, valid_q} + (inflight_q ? 6'd8 : 6'd0) <= 6'd8);

    if (start) begin
      state_d    = (expectedBytes == 16'd0) ? S_DONE : S_RUN;
      exp_d      = expectedBytes;
      issued_d   = 16'd0;
      returned_d = 16'd0;
      valid_d    = 5'd0;
      word_d     = 128'd0;
      err_d      = 1'b0;
    end else begin
      if (bus.consume_en && state_q != S_IDLE) begin
        win = word_q << {take, 3'b000};
        v   = valid_q - take;
        if (bus.consume_bytes > valid_q) err_d = 1'b1;
      end
      // Returning bytes land right after whatever survived this cycle's consume.
      if (inflight_q) begin
        win        = win | ({bus.imem_rdata & ret_mask, 64'd0} >> {v, 3'b000});
        v          = v + {1'b0, ret_n};
        returned_d = returned_q + {12'd0, ret_n};
      end
      word_d     = win;
      valid_d    = v;
      inflight_d = issue;
      if (issue) issued_d = issued_q + iss_n;
      if (state_q == S_RUN && issued_q == exp_q && returned_q == exp_q) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (resetB) begin
      state_q    <= S_IDLE;
      exp_q      <= 16'd0;
      issued_q   <= 16'd0;
      returned_q <= 16'd0;
      valid_q    <= 5'd0;
      inflight_q <= 1'b0;
      word_q     <= 128'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    bus.instruction_byte_valid = 16'd0;
    for (int i = 0; i < 16; i++) begin
      bus.instruction_byte_valid[15-i] = (i < int'(valid_q));
    end
  end

  assign bus.imem_ceb         = ~issue;
  assign bus.imem_addr        = issue ? (BASE_ADDR + {3'b000, issued_q[15:3]}) : 16'd0;
  assign bus.instruction_word = word_q;
  assign done_reading_memory  = (state_q == S_DONE);
  assign busy                 = (state_q == S_RUN);
  assign err_underflow        = err_q;

endmodule

// File: tb/tb_bits_ifetch.sv
// tb/tb_bits_ifetch.sv - randomized self-checking bench for bits_ifetch with a byte-queue reference model
module tb_bits_ifetch;
  logic        clk = 1'b0;
  logic        resetB = 1'b1;
  logic        start = 1'b0;
  logic [15:0] expectedBytes = 16'd0;
  logic        done_reading_memory, busy, err_underflow;

  bits_ifetch_if bus ();

  bits_ifetch #(.BASE_ADDR(16'h0000)) dut (
    .clk(clk), .resetB(resetB), .start(start), .expectedBytes(expectedBytes),
    .bus(bus), .done_reading_memory(done_reading_memory), .busy(busy),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int reads = 0;

  // Reference model: transmission state as a plain byte queue plus counters.
  int         m_state;  // 0 idle, 1 run, 2 done
  int         m_exp, m_issued, m_returned;
  bit         m_inflight, m_err;
  logic [7:0] m_q[$];
  bit         prev_rd;
  logic [15:0] prev_addr;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    if (a == 16'd0) return 64'h0011_2233_4455_6677;
    if (a == 16'd1) return 64'h8899_AABB_CCDD_EEFF;
    return {a * 16'h9E37 ^ 16'h5A5A, ~a, a ^ 16'hC3C3, a + 16'h1234};
  endfunction

  task automatic run_cycle(input bit rst, input bit st, input logic [15:0] e,
                           input bit cen, input logic [4:0] cb);
    bit exp_issue;
    int n, k, o_state, o_issued, o_returned;
    logic [127:0] ew;
    logic [15:0] ev;
    logic [63:0] rd;
    resetB = rst; start = st; expectedBytes = e;
    bus.consume_en = cen; bus.consume_bytes = cb;
    rd = prev_rd ? mem_word(prev_addr) : {$urandom, $urandom};
    bus.imem_rdata = rd;
    #1;
    exp_issue = !rst && m_state == 1 && !st && m_issued < m_exp &&
                (m_q.size() + (m_inflight ? 8 : 0)) <= 8;
    n_checks++;
    if (bus.imem_ceb !== !exp_issue) begin
      n_fail++;
      $display("FAIL imem_ceb: got %b expected %b", bus.imem_ceb, !exp_issue);
    end
    if (exp_issue) begin
      n_checks++;
      if (bus.imem_addr !== 16'(m_issued / 8)) begin
        n_fail++;
        $display("FAIL imem_addr: got %h expected %h", bus.imem_addr, 16'(m_issued / 8));
      end
    end
    if (bus.imem_ceb === 1'b0) reads++;
    prev_rd = (bus.imem_ceb === 1'b0);
    prev_addr = bus.imem_addr;

    o_state = m_state; o_issued = m_issued; o_returned = m_returned;
    if (rst) begin
      m_state = 0; m_exp = 0; m_issued = 0; m_returned = 0;
      m_inflight = 0; m_err = 0; m_q.delete();
    end else if (st) begin
      m_state = (e == 0) ? 2 : 1; m_exp = e; m_issued = 0; m_returned = 0;
      m_inflight = 0; m_err = 0; m_q.delete();
    end else begin
      if (m_state != 0 && cen) begin
        n = (cb > m_q.size()) ? m_q.size() : cb;
        if (cb > m_q.size()) m_err = 1;
        repeat (n) void'(m_q.pop_front());
      end
      if (m_inflight) begin
        k = (m_exp - m_returned > 8) ? 8 : m_exp - m_returned;
        for (int j = 0; j < k; j++) m_q.push_back(rd[63-8*j -: 8]);
        m_returned += k;
      end
      if (exp_issue) m_issued += (m_exp - m_issued > 8) ? 8 : m_exp - m_issued;
      m_inflight = exp_issue;
      if (o_state == 1 && o_issued == m_exp && o_returned == m_exp) m_state = 2;
    end

    @(posedge clk);
    #1;
    ew = '0; ev = '0;
    for (int j = 0; j < m_q.size(); j++) begin
      ew[127-8*j -: 8] = m_q[j];
      ev[15-j] = 1'b1;
    end
    n_checks += 5;
    if (bus.instruction_word !== ew) begin
      n_fail++;
      $display("FAIL window: got %h expected %h", bus.instruction_word, ew);
    end
    if (bus.instruction_byte_valid !== ev) begin
      n_fail++;
      $display("FAIL byte_valid: got %h expected %h", bus.instruction_byte_valid, ev);
    end
    if (done_reading_memory !== (m_state == 2)) begin
      n_fail++;
      $display("FAIL done: got %b expected %b", done_reading_memory, m_state == 2);
    end
    if (busy !== (m_state == 1)) begin
      n_fail++;
      $display("FAIL busy: got %b expected %b", busy, m_state == 1);
    end
    if (err_underflow !== m_err) begin
      n_fail++;
      $display("FAIL err_underflow: got %b expected %b", err_underflow, m_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (bus.imem_ceb !== 1'b1 || bus.imem_addr !== 16'd0 || bus.instruction_word !== 128'd0 ||
        bus.instruction_byte_valid !== 16'd0 || done_reading_memory !== 1'b0 ||
        busy !== 1'b0 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ceb=%b addr=%h valid=%h done=%b busy=%b err=%b required 1/0/0/0/0/0",
               bus.imem_ceb, bus.imem_addr, bus.instruction_byte_valid,
               done_reading_memory, busy, err_underflow);
    end
    run_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_full16;
    reads = 0;
    run_cycle(0, 1, 16, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'hFF00) begin
      n_fail++;
      $display("FAIL full16_t3: got %h expected ff00", bus.instruction_byte_valid);
    end
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'hFFFF ||
        bus.instruction_word !== 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF) begin
      n_fail++;
      $display("FAIL full16_t4: got %h/%h", bus.instruction_byte_valid, bus.instruction_word);
    end
    repeat (3) run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (done_reading_memory !== 1'b1 || reads != 2) begin
      n_fail++;
      $display("FAIL full16_done: done=%b reads=%0d expected 1 and 2", done_reading_memory, reads);
    end
  endtask

  task automatic test_len11;
    reads = 0;
    run_cycle(0, 1, 11, 0, 0);
    repeat (8) run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'hFFE0 || bus.instruction_word[39:0] !== 40'd0 ||
        done_reading_memory !== 1'b1 || reads != 2) begin
      n_fail++;
      $display("FAIL len11: valid=%h low=%h done=%b reads=%0d expected ffe0/0/1/2",
               bus.instruction_byte_valid, bus.instruction_word[39:0], done_reading_memory, reads);
    end
  endtask

  task automatic test_shift_append;
    logic [63:0] w1, w2;
    w1 = mem_word(16'd1); w2 = mem_word(16'd2);
    run_cycle(0, 1, 40, 0, 0);
    repeat (5) run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 5'd8);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 5'd5);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'hFFE0 || bus.instruction_word[127:104] !== w1[23:0] ||
        bus.instruction_word[103:40] !== w2) begin
      n_fail++;
      $display("FAIL shift_append: valid=%h word=%h", bus.instruction_byte_valid, bus.instruction_word);
    end
    repeat (12) run_cycle(0, 0, 0, 1, 5'($urandom_range(0, 6)));
  endtask

  task automatic test_underflow;
    run_cycle(0, 1, 4, 0, 0);
    repeat (5) run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'hF000) begin
      n_fail++;
      $display("FAIL uf_fill: got %h expected f000", bus.instruction_byte_valid);
    end
    run_cycle(0, 0, 0, 1, 5'd6);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'd0 || err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_set: valid=%h err=%b expected 0000/1", bus.instruction_byte_valid, err_underflow);
    end
    repeat (3) run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (err_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_sticky: got %b expected 1", err_underflow);
    end
    run_cycle(0, 1, 8, 0, 0);
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clear: got %b expected 0", err_underflow);
    end
  endtask

  task automatic test_restart_zero;
    int r0;
    run_cycle(0, 1, 32, 0, 0);
    repeat (3) run_cycle(0, 0, 0, 0, 0);
    r0 = reads;
    run_cycle(0, 1, 0, 0, 0);
    n_checks++;
    if (reads != r0 || bus.instruction_byte_valid !== 16'd0 || done_reading_memory !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_zero: reads+%0d valid=%h done=%b expected +0/0000/1",
               reads - r0, bus.instruction_byte_valid, done_reading_memory);
    end
    repeat (2) run_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midrun;
    run_cycle(0, 1, 32, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'd0 || bus.instruction_word !== 128'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: valid=%h busy=%b expected 0000/0", bus.instruction_byte_valid, busy);
    end
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.instruction_byte_valid !== 16'd0 || bus.imem_ceb !== 1'b1) begin
      n_fail++;
      $display("FAIL late_rdata: valid=%h ceb=%b expected 0000/1", bus.instruction_byte_valid, bus.imem_ceb);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 399) == 0)
        run_cycle(1, 0, 0, 0, 0);
      else if ($urandom_range(0, 59) == 0 || c == 0)
        run_cycle(0, 1, 16'($urandom_range(0, 60)), 1'($urandom), 5'($urandom_range(0, 16)));
      else
        run_cycle(0, 0, 16'($urandom), 1'($urandom),
                  5'($urandom_range(0, 9) == 0 ? $urandom_range(0, 16) : $urandom_range(0, 6)));
    end
  endtask

  initial begin
    m_state = 0; m_exp = 0; m_issued = 0; m_returned = 0;
    m_inflight = 0; m_err = 0; prev_rd = 0; prev_addr = 16'd0;
    bus.consume_en = 1'b0; bus.consume_bytes = 5'd0; bus.imem_rdata = 64'd0;
    @(negedge clk);
    test_reset;
    test_full16;
    test_len11;
    test_shift_append;
    test_underflow;
    test_restart_zero;
    test_reset_midrun;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
